// File: rtl/uart_bus_master.sv
// uart_bus_master: parses 'W'/'R' byte frames from the UART receiver,
// runs one peripheral bus transaction and returns status or read data.
module uart_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [7:0]  CMD_WRITE      = 8'h57,
    parameter logic [7:0]  CMD_READ       = 8'h52
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_we,
    output logic        bus_valid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,
    output logic        busy
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_RESP,
        S_TXWAIT
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_nx;
    logic [1:0]  cnt;
    logic [15:0] tcnt;
    logic [31:0] rdata_q;
    logic        err;
    logic [1:0]  ridx;
    logic        skip;

    logic        is_cmd;
    logic        last_byte;
    logic        tmo;
    logic        more;
    logic [7:0]  resp_byte;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (rx_valid && is_cmd) state_nx = S_ADDR;
            S_ADDR:   if (last_byte) state_nx = bus_we ? S_DATA : S_BUS;
            S_DATA:   if (last_byte) state_nx = S_BUS;
            S_BUS:    if (bus_ready || tmo) state_nx = S_RESP;
            S_RESP:   if (!tx_busy) state_nx = S_TXWAIT;
            S_TXWAIT: begin
                if (!skip && !tx_busy) state_nx = more ? S_RESP : S_IDLE;
            end
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        is_cmd    = (rx_data == CMD_WRITE) || (rx_data == CMD_READ);
        last_byte = rx_valid && (cnt == 2'd3);
        tmo       = (tcnt == TMO_LAST);
        more      = !err && !bus_we && (ridx != 2'd3);
        bus_valid = (state == S_BUS);
        busy      = (state != S_IDLE);
        // Error wins over write ack; reads stream rdata MSB first.
        if (err) begin
            resp_byte = 8'h45;
        end else if (bus_we) begin
            resp_byte = 8'h4B;
        end else begin
            unique case (ridx)
                2'd0:    resp_byte = rdata_q[31:24];
                2'd1:    resp_byte = rdata_q[23:16];
                2'd2:    resp_byte = rdata_q[15:8];
                default: resp_byte = rdata_q[7:0];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_we    <= 1'b0;
            tx_data   <= '0;
            tx_start  <= 1'b0;
            cnt       <= '0;
            tcnt      <= '0;
            rdata_q   <= '0;
            err       <= 1'b0;
            ridx      <= '0;
            skip      <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            tcnt     <= '0;
            unique case (state)
                S_IDLE: begin
                    cnt <= 2'd0;
                    if (rx_valid && is_cmd) begin
                        bus_we <= (rx_data == CMD_WRITE);
                    end
                end
                S_ADDR: begin
                    if (rx_valid) begin
                        bus_addr <= {bus_addr[23:0], rx_data};
                        cnt      <= cnt + 2'd1;
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        bus_wdata <= {bus_wdata[23:0], rx_data};
                        cnt       <= cnt + 2'd1;
                    end
                end
                S_BUS: begin
                    tcnt <= tcnt + 16'd1;
                    ridx <= 2'd0;
                    if (bus_ready) begin
                        rdata_q <= bus_rdata;
                        err     <= 1'b0;
                    end else if (tmo) begin
                        err <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (!tx_busy) begin
                        tx_data  <= resp_byte;
                        tx_start <= 1'b1;
                        skip     <= 1'b1;
                    end
                end
                S_TXWAIT: begin
                    // tx_busy may lag tx_start by a cycle, so the first cycle is ignored.
                    skip <= 1'b0;
                    if (!skip && !tx_busy && more) begin
                        ridx <= ridx + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
